// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle for uart_rx_cfg: serial line in, word/flags out with valid/ready.
// master = the receiver core, slave = the consumer that also drives the line.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_frame_err;
    logic                  rx_parity_err;
    logic                  rx_overrun;
    logic                  rx_busy;

    modport master (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_parity_err,
        output rx_overrun,
        output rx_busy
    );

    modport slave (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_overrun,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// false-start rejection, parity/framing flags and a valid/ready output with overrun pulse.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | start bit; a voted 1 is treated as a glitch and abandoned
// DATA      | payload bits, LSB first
// PARITY    | parity bit (only when PARITY != 0)
// STOP      | stop bit(s); frame completes at the vote of the last one
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_cfg #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1667,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input logic            clk,
    input logic            rst,
    uart_rx_cfg_if.master  bus
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_S0   = TW'(H - 1);
    localparam logic [TW-1:0] T_S1   = TW'(H);
    localparam logic [TW-1:0] T_VOTE = TW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic          PAR_TARGET = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                state_q;
    logic                  rx_meta_q;
    logic                  rx_s_q;
    logic [TW-1:0]         timer_q;
    logic [IW-1:0]         bit_idx_q;
    logic                  stop_idx_q;
    logic [1:0]            smp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  ferr_acc_q;
    logic                  perr_acc_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  ferr_q;
    logic                  perr_q;
    logic                  ovr_q;
    logic                  busy_q;

    logic voted;
    logic at_vote;
    logic at_wrap;
    logic frame_ferr;
    logic can_load;

    assign voted      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign at_vote    = (timer_q == T_VOTE);
    assign at_wrap    = (timer_q == T_LAST);
    assign frame_ferr = ferr_acc_q | ~voted;
    assign can_load   = ~valid_q | bus.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            smp_q      <= 2'b11;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            perr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            ovr_q     <= 1'b0;

            if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end

            if (state_q != S_IDLE) begin
                timer_q <= at_wrap ? '0 : timer_q + 1'b1;
            end
            if (timer_q == T_S0) begin
                smp_q[0] <= rx_s_q;
            end
            if (timer_q == T_S1) begin
                smp_q[1] <= rx_s_q;
            end

            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (!rx_s_q) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        ferr_acc_q <= 1'b0;
                        perr_acc_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_vote && voted) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                    end else if (at_wrap) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_vote) begin
                        shift_q[bit_idx_q] <= voted;
                    end
                    if (at_wrap) begin
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_vote) begin
                        perr_acc_q <= ((^shift_q) ^ voted) != PAR_TARGET;
                    end
                    if (at_wrap) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_vote) begin
                        if (stop_idx_q == STOP_LAST) begin
                            // Complete mid-bit so a back-to-back start edge is not missed.
                            state_q <= frame_ferr ? S_WAIT_HIGH : S_IDLE;
                            busy_q  <= frame_ferr;
                            timer_q <= '0;
                            if (can_load) begin
                                data_q  <= shift_q;
                                ferr_q  <= frame_ferr;
                                perr_q  <= perr_acc_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_acc_q <= frame_ferr;
                        end
                    end
                    if (at_wrap) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    timer_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.rx_frame_err  = ferr_q;
    assign bus.rx_parity_err = perr_q;
    assign bus.rx_overrun    = ovr_q;
    assign bus.rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations share clock/reset; frames are built bit by bit
// and delivered words are compared against expectations computed from the frame contents.
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;
    logic rdy = 1'b1;
    int   sel = 0;

    int dw_of   [3] = '{8, 8, 9};
    int par_of  [3] = '{0, 2, 1};
    int stop_of [3] = '{1, 1, 2};

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_WIDTH(8)) if0 ();
    uart_rx_cfg_if #(.DATA_WIDTH(8)) if1 ();
    uart_rx_cfg_if #(.DATA_WIDTH(9)) if2 ();

    assign if0.rx = (sel == 0) ? line : 1'b1;
    assign if1.rx = (sel == 1) ? line : 1'b1;
    assign if2.rx = (sel == 2) ? line : 1'b1;
    assign if0.rx_ready = rdy;
    assign if1.rx_ready = rdy;
    assign if2.rx_ready = rdy;

    uart_rx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0.master));
    uart_rx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.master));
    uart_rx_cfg #(.DATA_WIDTH(9), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst), .bus(if2.master));

    logic       obs_valid, obs_ferr, obs_perr, obs_ovr, obs_busy;
    logic [8:0] obs_data;

    always_comb begin
        obs_valid = 1'b0;
        obs_ferr  = 1'b0;
        obs_perr  = 1'b0;
        obs_ovr   = 1'b0;
        obs_busy  = 1'b0;
        obs_data  = '0;
        case (sel)
            0: begin
                obs_valid = if0.rx_valid; obs_ferr = if0.rx_frame_err; obs_perr = if0.rx_parity_err;
                obs_ovr = if0.rx_overrun; obs_busy = if0.rx_busy; obs_data = {1'b0, if0.rx_data};
            end
            1: begin
                obs_valid = if1.rx_valid; obs_ferr = if1.rx_frame_err; obs_perr = if1.rx_parity_err;
                obs_ovr = if1.rx_overrun; obs_busy = if1.rx_busy; obs_data = {1'b0, if1.rx_data};
            end
            default: begin
                obs_valid = if2.rx_valid; obs_ferr = if2.rx_frame_err; obs_perr = if2.rx_parity_err;
                obs_ovr = if2.rx_overrun; obs_busy = if2.rx_busy; obs_data = if2.rx_data;
            end
        endcase
    end

    // Every accepted word (valid & ready seen between edges) is logged as {perr, ferr, data}.
    always @(negedge clk) begin
        if (!rst) begin
            if (obs_valid && rdy) got_q.push_back({obs_perr, obs_ferr, obs_data});
            if (obs_ovr) ovr_cnt++;
        end
    end

    task automatic drive(input logic b, input int n);
        line = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input logic pbit, input logic [1:0] stops,
                              input int glitch_bit);
        drive(1'b0, CPB);
        for (int i = 0; i < dw_of[sel]; i++) begin
            if (i == glitch_bit) begin
                drive(d[i], H + 1);
                drive(~d[i], 1);
                drive(d[i], CPB - H - 2);
            end else begin
                drive(d[i], CPB);
            end
        end
        if (par_of[sel] != 0) drive(pbit, CPB);
        for (int s = 0; s < stop_of[sel]; s++) drive(stops[s], CPB);
        line = 1'b1;
    endtask

    function automatic logic good_parity(input logic [8:0] d);
        int ones = $countones(d);
        if (par_of[sel] == 1) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    function automatic logic [10:0] exp_word(input logic [8:0] d, input logic pbit,
                                             input logic [1:0] stops);
        int   ones = $countones(d) + int'(pbit);
        logic perr = 1'b0;
        logic ferr;
        if (par_of[sel] == 1) perr = (ones % 2 == 0);
        if (par_of[sel] == 2) perr = (ones % 2 == 1);
        ferr = !stops[0] || (stop_of[sel] == 2 && !stops[1]);
        return {perr, ferr, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d got %b exp 0", s, obs_valid); end
            checks++; if (obs_data !== 9'h0) begin errors++; $display("FAIL reset_data dut%0d got %h exp 0", s, obs_data); end
            checks++; if (obs_ferr !== 1'b0 || obs_perr !== 1'b0) begin errors++; $display("FAIL reset_flags dut%0d got %b%b exp 00", s, obs_ferr, obs_perr); end
            checks++; if (obs_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun dut%0d got %b exp 0", s, obs_ovr); end
            checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", s, obs_busy); end
        end
        sel = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 4);
    endtask

    task automatic test_basic();
        sel = 0; rdy = 1'b1; got_q.delete();
        send_frame(9'h0A5, 1'b0, 2'b11, -1);
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL basic_count got %0d exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h0A5) begin errors++; $display("FAIL basic_word got %h exp %h", got_q[0], 11'h0A5); end
        end
    endtask

    task automatic test_parity();
        sel = 1; rdy = 1'b1; got_q.delete();
        send_frame(9'h003, 1'b0, 2'b11, -1);
        drive(1'b1, 5);
        send_frame(9'h003, 1'b1, 2'b11, -1);
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL parity_count got %0d exp 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h003) begin errors++; $display("FAIL parity_even_ok got %h exp %h", got_q[0], 11'h003); end
            checks++;
            if (got_q[1] !== 11'h403) begin errors++; $display("FAIL parity_even_bad got %h exp %h", got_q[1], 11'h403); end
        end
    endtask

    task automatic test_glitch();
        sel = 0; rdy = 1'b1; got_q.delete();
        drive(1'b0, 4);
        drive(1'b1, 2);
        checks++;
        if (obs_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_rise got %b exp 1", obs_busy); end
        drive(1'b1, 12);
        checks++;
        if (obs_busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_drop got %b exp 0", obs_busy); end
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL false_start_words got %0d exp 0", got_q.size()); end
        got_q.delete();
        send_frame(9'h03C, 1'b0, 2'b11, 2);
        drive(1'b1, 5);
        send_frame(9'h0C3, 1'b0, 2'b11, 5);
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL glitch_count got %0d exp 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h03C || got_q[1] !== 11'h0C3) begin
                errors++; $display("FAIL glitch_words got %h %h exp 03c 0c3", got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_break();
        sel = 0; rdy = 1'b1; got_q.delete();
        drive(1'b0, 20 * CPB);
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("FAIL break_during_low got %0d exp 1", got_q.size()); end
        drive(1'b1, 2 * CPB);
        send_frame(9'h05A, 1'b0, 2'b11, -1);
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL break_count got %0d exp 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h200) begin errors++; $display("FAIL break_word got %h exp %h", got_q[0], 11'h200); end
            checks++;
            if (got_q[1] !== 11'h05A) begin errors++; $display("FAIL break_recover got %h exp %h", got_q[1], 11'h05A); end
        end
    endtask

    task automatic test_overrun();
        sel = 0; rdy = 1'b0; got_q.delete(); ovr_cnt = 0;
        send_frame(9'h011, 1'b0, 2'b11, -1);
        drive(1'b1, 5);
        send_frame(9'h022, 1'b0, 2'b11, -1);
        drive(1'b1, CPB);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 9'h011) begin
            errors++; $display("FAIL overrun_hold got valid %b data %h exp 1 011", obs_valid, obs_data);
        end
        checks++;
        if (ovr_cnt !== 1) begin errors++; $display("FAIL overrun_pulses got %0d exp 1", ovr_cnt); end
        rdy = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL overrun_release got %b exp 0", obs_valid); end
        checks++;
        if (obs_data !== 9'h011) begin errors++; $display("FAIL overrun_data_kept got %h exp 011", obs_data); end
        drive(1'b1, CPB);
    endtask

    task automatic test_reset_mid_frame();
        sel = 2; rdy = 1'b1; got_q.delete();
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b0, CPB);
        drive(1'b1, CPB / 2);
        rst = 1'b1;
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 3 * CPB);
        checks++;
        if (got_q.size() !== 0 || obs_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_output got words %0d valid %b exp 0 0", got_q.size(), obs_valid);
        end
        checks++;
        if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b exp 0", obs_busy); end
        send_frame(9'h1FF, good_parity(9'h1FF), 2'b11, -1);
        drive(1'b1, 2 * CPB);
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL reset_mid_count got %0d exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 11'h1FF) begin errors++; $display("FAIL reset_mid_word got %h exp %h", got_q[0], 11'h1FF); end
        end
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        for (int s = 0; s < 3; s++) begin
            sel = s; rdy = 1'b1; got_q.delete(); exp_q.delete();
            repeat (12) begin
                d = 9'($urandom) & 9'((1 << dw_of[s]) - 1);
                pbit = good_parity(d);
                if ($urandom_range(0, 3) == 0) pbit = ~pbit;
                stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
                exp_q.push_back(exp_word(d, pbit, stops));
                send_frame(d, pbit, stops, -1);
                drive(1'b1, 4 + $urandom_range(0, 8));
            end
            drive(1'b1, 2 * CPB);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL random_count dut%0d got %0d exp %0d", s, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++; $display("FAIL random_word dut%0d #%0d got %h exp %h", s, i, got_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
